wb_stage: RTL

// - Write-back stage of the 5-stage RV32I pipeline; consumes the 167-bit MEM/WB bundle

---
 rtl/wb_stage_pkg.sv | 42 ++++
 rtl/wb_regfile.sv | 52 +++++
 rtl/wb_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the RV32I write-back stage:
//   - opcode-class constants decoded from instr[6:1]
//   - funct3 load-width codes
//   - bit ranges of the 167-bit MEM/WB bundle
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  // instr[6:1] opcode classes (instr[0] is always 1 for 32-bit encodings)
  localparam logic [5:0] OPC_LOAD   = 6'b000001;
  localparam logic [5:0] OPC_LUI    = 6'b011011;
  localparam logic [5:0] OPC_AUIPC  = 6'b001011;
  localparam logic [5:0] OPC_JAL    = 6'b110111;
  localparam logic [5:0] OPC_JALR   = 6'b110011;
  localparam logic [5:0] OPC_OP     = 6'b011001;
  localparam logic [5:0] OPC_OPIMM  = 6'b001001;

  // funct3 load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // MEM/WB bundle layout
  localparam int MW_W      = 167;
  localparam int MW_PC_LO  = 0;
  localparam int MW_PC_HI  = 31;
  localparam int MW_IMM_LO = 32;
  localparam int MW_IMM_HI = 63;
  localparam int MW_DRD_LO = 64;
  localparam int MW_DRD_HI = 95;
  localparam int MW_ALU_LO = 96;
  localparam int MW_ALU_HI = 127;
  localparam int MW_OPC_LO = 128;
  localparam int MW_OPC_HI = 133;
  localparam int MW_STD_LO = 134;
  localparam int MW_STD_HI = 165;
  localparam int MW_VLD    = 166;

endpackage

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// 2-read / 1-write architectural register file with x0 hardwired to zero and
// write-through bypass on both read ports.
// Ports:
//   clk, rst_n               clock, async active-low reset (clears all entries)
//   we_i, waddr_i, wdata_i   write port, committed at posedge clk
//   raddr1_i/raddr2_i        read addresses
//   rdata1_o/rdata2_o        combinational read data (bypassed)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A write and a read of the same register in one cycle returns the value
  // being written, so decode never sees a stale operand.
  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] ra,
                                              input logic [XLEN-1:0] arr_val,
                                              input logic we,
                                              input logic [AW-1:0] wa,
                                              input logic [XLEN-1:0] wd);
    if (ra == '0)             return '0;
    else if (we && (wa == ra)) return wd;
    else                       return arr_val;
  endfunction

  assign rdata1_o = rd_port(raddr1_i, mem_q[raddr1_i], we_i, waddr_i, wdata_i);
  assign rdata2_o = rd_port(raddr2_i, mem_q[raddr2_i], we_i, waddr_i, wdata_i);

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the 5-stage RV32I pipeline. Consumes the MEM/WB bundle,
// selects the write-back value, aligns/extends load data and owns the register
// file. Also keeps a retired-bundle counter and a sticky misaligned-load trap.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reg_mem_wb                 167-bit MEM/WB bundle (pc/imm/drdata/alu/op/valid)
//   mem_wb_rd, mem_wb_f3       destination register and funct3 for the bundle
//   rs1_addr/rs2_addr          decode read addresses
//   rs1_data/rs2_data          bypassed read data
//   fwd_we/fwd_rd/fwd_data     registered copy of the last write for EX forwarding
//   instret                    retired-bundle counter
//   err_clr                    clears the sticky trap
//   ld_misalign, err_pc        sticky misaligned-load flag and first faulting pc
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MW_W-1:0]  reg_mem_wb,
  input  logic [4:0]       mem_wb_rd,
  input  logic [2:0]       mem_wb_f3,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             fwd_we,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret,
  input  logic             err_clr,
  output logic             ld_misalign,
  output logic [XLEN-1:0]  err_pc
);

  // Bundle fields
  logic [XLEN-1:0] pc, imm, drdata, alu_out;
  logic [5:0]      opc;
  logic            valid;

  assign pc      = reg_mem_wb[MW_PC_HI:MW_PC_LO];
  assign imm     = reg_mem_wb[MW_IMM_HI:MW_IMM_LO];
  assign drdata  = reg_mem_wb[MW_DRD_HI:MW_DRD_LO];
  assign alu_out = reg_mem_wb[MW_ALU_HI:MW_ALU_LO];
  assign opc     = reg_mem_wb[MW_OPC_HI:MW_OPC_LO];
  assign valid   = reg_mem_wb[MW_VLD];

  // Store data is carried in the bundle but has no use at write-back.
  logic unused_store_data;
  assign unused_store_data = ^reg_mem_wb[MW_STD_HI:MW_STD_LO];

  // Load alignment: pick the addressed lane, then sign/zero extend.
  // Unknown funct3 yields zero (the write still happens).
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    unique case (f3)
      F3_LB:   return {{(XLEN-8){b[7]}}, b};
      F3_LBU:  return {{(XLEN-8){1'b0}}, b};
      F3_LH:   return {{(XLEN-16){h[15]}}, h};
      F3_LHU:  return {{(XLEN-16){1'b0}}, h};
      F3_LW:   return word;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    if ((f3 == F3_LH) || (f3 == F3_LHU)) return off[0];
    else if (f3 == F3_LW)                return off != 2'b00;
    else                                 return 1'b0;
  endfunction

  // Class decode / value select
  logic            wr_class;
  logic            is_load;
  logic [XLEN-1:0] wb_value;

  always_comb begin
    wr_class = 1'b0;
    is_load  = 1'b0;
    wb_value = '0;
    case (opc)
      OPC_LOAD: begin
        wr_class = 1'b1;
        is_load  = 1'b1;
        wb_value = load_extract(mem_wb_f3, alu_out[1:0], drdata);
      end
      OPC_LUI: begin
        wr_class = 1'b1;
        wb_value = imm;
      end
      OPC_AUIPC: begin
        wr_class = 1'b1;
        wb_value = pc + imm;
      end
      OPC_JAL, OPC_JALR: begin
        wr_class = 1'b1;
        wb_value = pc + XLEN'(4);
      end
      OPC_OP, OPC_OPIMM: begin
        wr_class = 1'b1;
        wb_value = alu_out;
      end
      default: ;
    endcase
  end

  logic misalign;
  logic we;

  // Misalignment is reported even for rd=0; only the write is gated by rd.
  assign misalign = valid & is_load & is_misaligned(mem_wb_f3, alu_out[1:0]);

  // rst_n gating keeps a bundle held during reset from reaching the array or
  // the bypass path, so reads show zero for the whole reset window.
  assign we = rst_n & valid & wr_class & ~misalign & (mem_wb_rd != 5'd0);

  wb_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .waddr_i  (mem_wb_rd),
    .wdata_i  (wb_value),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // Forwarding copy, counter and trap state
  logic             fwd_we_q, fwd_we_d;
  logic [4:0]       fwd_rd_q, fwd_rd_d;
  logic [XLEN-1:0]  fwd_data_q, fwd_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             flag_q, flag_d;
  logic [XLEN-1:0]  err_pc_q, err_pc_d;

  always_comb begin
    fwd_we_d   = we;
    fwd_rd_d   = fwd_rd_q;
    fwd_data_d = fwd_data_q;
    instret_d  = instret_q;
    flag_d     = flag_q;
    err_pc_d   = err_pc_q;

    if (valid) begin
      fwd_rd_d   = mem_wb_rd;
      fwd_data_d = wb_value;
      instret_d  = instret_q + CNT_W'(1);
    end

    // A new fault on the clearing edge wins; otherwise keep the first pc.
    if (misalign) begin
      flag_d = 1'b1;
      if (!flag_q || err_clr) err_pc_d = pc;
    end else if (err_clr) begin
      flag_d   = 1'b0;
      err_pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_we_q   <= 1'b0;
      fwd_rd_q   <= '0;
      fwd_data_q <= '0;
      instret_q  <= '0;
      flag_q     <= 1'b0;
      err_pc_q   <= '0;
    end else begin
      fwd_we_q   <= fwd_we_d;
      fwd_rd_q   <= fwd_rd_d;
      fwd_data_q <= fwd_data_d;
      instret_q  <= instret_d;
      flag_q     <= flag_d;
      err_pc_q   <= err_pc_d;
    end
  end

  assign fwd_we      = fwd_we_q;
  assign fwd_rd      = fwd_rd_q;
  assign fwd_data    = fwd_data_q;
  assign instret     = instret_q;
  assign ld_misalign = flag_q;
  assign err_pc      = err_pc_q;

endmodule
